// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU data-memory request/response bundle
// Purpose: groups the CPU-side data-memory handshake into one interface.
// Signals:
//   mem_read, mem_write   level requests, held by the master until mem_resp
//   mem_address           byte address, word index = mem_address[31:2]
//   mem_wdata, mem_wmask  write data and per-byte-lane enables
//   mem_rdata, mem_resp, mem_err  one-cycle response returned by the slave
// Modports: master (CPU side), slave (memory side).
interface dmem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_wmask,
    input  mem_rdata, mem_resp, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_wmask,
    output mem_rdata, mem_resp, mem_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency word-addressed data memory responder
// Purpose: accepts one CPU data request at a time, waits a fixed latency and
//   returns a single-cycle response; writes are byte-lane masked.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (store contents are kept)
//   mem    dmem_responder_if.slave request/response bundle
// Parameters:
//   DEPTH_WORDS  words in the backing store (power of two, 16..4096)
//   LATENCY      cycles from acceptance to response (1..15)
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave mem
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wmask_q, wmask_d;
  logic            wr_q, wr_d;
  logic            err_q, err_d;

  logic [31:0]     store_q [DEPTH_WORDS];

  logic            req_in;
  logic            err_in;
  logic            resp;
  logic            unused_addr_bits;

  assign req_in = mem.mem_read | mem.mem_write;
  // Conflicting request type or an index past the end of the store.
  assign err_in = (mem.mem_read & mem.mem_write) |
                  (mem.mem_address[31:2] >= 30'(DEPTH_WORDS));
  assign unused_addr_bits = &{1'b0, mem.mem_address[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_in) begin
          idx_d   = mem.mem_address[AW+1:2];
          wdata_d = mem.mem_wdata;
          wmask_d = mem.mem_wmask;
          wr_d    = mem.mem_write;
          err_d   = err_in;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Commit on the edge that ends RESP; reset on that edge cancels the write.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == ST_RESP) && wr_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) begin
          store_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign resp          = (state_q == ST_RESP);
  assign mem.mem_resp  = resp;
  assign mem.mem_err   = resp & err_q;
  assign mem.mem_rdata = (resp && !wr_q && !err_q) ? store_q[idx_q] : 32'h0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;
  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_responder_if if0 ();
  dmem_responder_if if1 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u0 (
    .clk(clk), .rst_n(rst_n), .mem(if0)
  );
  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .mem(if1)
  );

  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  bit          mon_en = 1'b0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model [DEPTH];

  bit          u1_rec = 1'b0;
  int          u1_hi  = 0;
  int          u1_cycles[$];
  logic [31:0] u1_exp = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Scoreboard monitor for the LATENCY=2 instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (if0.mem_resp === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rdata", if0.mem_rdata, mon_e.rdata);
          check("err", {31'b0, if0.mem_err}, {31'b0, mon_e.err});
          check("resp_cycle", cyc, mon_e.cyc);
        end
      end else begin
        check("idle_resp", {31'b0, if0.mem_resp}, 32'd0);
        check("idle_rdata", if0.mem_rdata, 32'd0);
        check("idle_err", {31'b0, if0.mem_err}, 32'd0);
      end
    end
  end

  // Pulse recorder for the LATENCY=1 instance.
  always @(negedge clk) begin
    if (mon_en && u1_rec && if1.mem_resp === 1'b1) begin
      u1_hi <= u1_hi + 1;
      u1_cycles.push_back(cyc);
      check("u1_rdata", if1.mem_rdata, u1_exp);
    end
  end

  // Drive one request, predict its response, hold it until the RESP cycle.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] wm, input bit perturb);
    exp_t        e;
    logic [29:0] idx;
    idx = addr[31:2];
    @(negedge clk);
    if0.mem_read    = rd;
    if0.mem_write   = wr;
    if0.mem_address = addr;
    if0.mem_wdata   = wd;
    if0.mem_wmask   = wm;
    // Accepted at the next edge; RESP is the cycle ending LAT edges later.
    e.cyc = cyc + LAT;
    if ((rd && wr) || (idx >= 30'(DEPTH))) begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
    end else if (rd) begin
      e.rdata = model[idx[7:0]];
      e.err   = 1'b0;
    end else begin
      e.rdata = 32'h0;
      e.err   = 1'b0;
      for (int i = 0; i < 4; i++)
        if (wm[i]) model[idx[7:0]][8*i +: 8] = wd[8*i +: 8];
    end
    sb.push_back(e);
    @(posedge clk);
    if (perturb) begin
      @(negedge clk);
      if0.mem_read    = 1'b0;
      if0.mem_write   = 1'b0;
      if0.mem_address = $urandom;
      if0.mem_wdata   = $urandom;
    end
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    if0.mem_read  = 1'b0;
    if0.mem_write = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          kind;
    int          c;
    int          k;

    rst_n = 1'b0;
    if0.mem_read = 1'b0; if0.mem_write = 1'b0; if0.mem_address = '0;
    if0.mem_wdata = '0;  if0.mem_wmask = '0;
    if1.mem_read = 1'b0; if1.mem_write = 1'b0; if1.mem_address = '0;
    if1.mem_wdata = '0;  if1.mem_wmask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Define every word so later reads have known contents.
    for (int w = 0; w < DEPTH; w++) issue(1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF, 1'b0);

    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    issue(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0);
    issue(1'b1, 1'b0, 32'h13, 32'h0, 4'h0, 1'b0);
    issue(1'b1, 1'b1, 32'h10, 32'h55555555, 4'hF, 1'b0);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    issue(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0);
    issue(1'b0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 1'b0);
    issue(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0);

    // Write aborted by reset during WAIT: no response, store untouched.
    @(negedge clk);
    if0.mem_write = 1'b1; if0.mem_address = 32'h20;
    if0.mem_wdata = 32'hCAFEF00D; if0.mem_wmask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; if0.mem_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);

    // Inputs perturbed during WAIT must not disturb the latched read.
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 99);
      a = {30'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))};
      d = $urandom;
      if (kind < 45)      issue(1'b1, 1'b0, a, d, 4'($urandom), kind < 10);
      else if (kind < 85) issue(1'b0, 1'b1, a, d, 4'($urandom), 1'b0);
      else if (kind < 92) issue(1'b1, 1'b1, a, d, 4'($urandom), 1'b0);
      else begin
        a = {30'($urandom_range(DEPTH, 1 << 20)), 2'b00};
        issue(kind[0], ~kind[0], a, d, 4'hF, 1'b0);
      end
    end

    // LATENCY=1 instance: write, then a read held across two transactions.
    @(negedge clk);
    if1.mem_write = 1'b1; if1.mem_address = 32'h4;
    if1.mem_wdata = 32'hA5C3_0F96; if1.mem_wmask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    if1.mem_write = 1'b0;
    @(negedge clk);
    u1_exp = 32'hA5C3_0F96;
    u1_rec = 1'b1;
    if1.mem_read = 1'b1;
    c = cyc;
    repeat (4) @(posedge clk);
    @(negedge clk);
    if1.mem_read = 1'b0;
    repeat (3) @(negedge clk);
    u1_rec = 1'b0;
    check("u1_high_samples", u1_hi, 32'd2);
    if (u1_cycles.size() >= 2) begin
      check("u1_first_resp", u1_cycles[0], c + 1);
      check("u1_spacing", u1_cycles[1] - u1_cycles[0], 32'd2);
    end else begin
      check("u1_pulse_count", u1_cycles.size(), 32'd2);
    end

    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("drain", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
